// File: rtl/clic_core_rx.sv
// Core-side responder for the CLIC interrupt handshake: captures an offered irq, gates it on live core state, raises a trap request and closes with ready (commit) or kill_ack (abort).
// Optional build macro CLIC_RX_VIRT_EN adds virtual-supervisor (guest id) gating of virtualized irqs.
module clic_core_rx #(
    parameter int N_SOURCE  = 256,
    parameter int PrioWidth = 8,
    parameter int ModeWidth = 2,
    parameter int VsidWidth = 6,
    localparam int SrcWidth = $clog2(N_SOURCE)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 irq_valid_i,
    output logic                 irq_ready_o,
    input  logic [SrcWidth-1:0]  irq_id_i,
    input  logic [PrioWidth-1:0] irq_max_i,
    input  logic [ModeWidth-1:0] irq_mode_i,
    input  logic [VsidWidth-1:0] irq_vsid_i,
    input  logic                 irq_v_i,
    input  logic                 irq_shv_i,
    input  logic                 irq_kill_req_i,
    output logic                 irq_kill_ack_o,
    input  logic [ModeWidth-1:0] priv_i,
    input  logic                 mie_i,
    input  logic                 sie_i,
    input  logic [PrioWidth-1:0] mil_i,
    input  logic [PrioWidth-1:0] sil_i,
    input  logic [PrioWidth-1:0] mthresh_i,
    input  logic [PrioWidth-1:0] sthresh_i,
    input  logic                 virt_i,
    input  logic [VsidWidth-1:0] cur_vsid_i,
    input  logic                 take_ok_i,
    output logic                 trap_req_o,
    input  logic                 trap_ack_i,
    output logic [SrcWidth-1:0]  trap_id_o,
    output logic [PrioWidth-1:0] trap_level_o,
    output logic [ModeWidth-1:0] trap_mode_o,
    output logic [VsidWidth-1:0] trap_vsid_o,
    output logic                 trap_v_o,
    output logic                 trap_shv_o
);

    localparam logic [ModeWidth-1:0] MODE_M = ModeWidth'(3);
    localparam logic [ModeWidth-1:0] MODE_S = ModeWidth'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_REQ,
        ST_HSK,
        ST_KILL
    } state_e;

    state_e state_q, state_d;

    logic [SrcWidth-1:0]  id_q, id_d;
    logic [PrioWidth-1:0] level_q, level_d;
    logic [ModeWidth-1:0] mode_q, mode_d;
    logic                 shv_q, shv_d;
    logic                 capture;
    logic                 elig;
    logic                 cur_ie;
    logic [PrioWidth-1:0] cur_il;
    logic [PrioWidth-1:0] cur_th;
    logic [PrioWidth-1:0] cur_floor;

    // Fields are only ever sampled on the IDLE->PEND transition.
    assign capture = (state_q == ST_IDLE) && irq_valid_i;

    always_comb begin
        id_d    = id_q;
        level_d = level_q;
        mode_d  = mode_q;
        shv_d   = shv_q;
        if (capture) begin
            id_d    = irq_id_i;
            level_d = irq_max_i;
            mode_d  = irq_mode_i;
            shv_d   = irq_shv_i;
        end
    end

`ifdef CLIC_RX_VIRT_EN
    logic [VsidWidth-1:0] vsid_q, vsid_d;
    logic                 v_q, v_d;
    logic                 virt_match;

    always_comb begin
        vsid_d = vsid_q;
        v_d    = v_q;
        if (capture) begin
            vsid_d = irq_vsid_i;
            v_d    = irq_v_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vsid_q <= '0;
            v_q    <= 1'b0;
        end else begin
            vsid_q <= vsid_d;
            v_q    <= v_d;
        end
    end

    // A guest irq may only be taken while that same guest is running.
    assign virt_match  = !v_q || (virt_i && (vsid_q == cur_vsid_i));
    assign trap_vsid_o = vsid_q;
    assign trap_v_o    = v_q;
`else
    logic virt_match;
    logic unused_virt;

    assign virt_match  = 1'b1;
    assign unused_virt = ^{irq_vsid_i, irq_v_i, virt_i, cur_vsid_i};
    assign trap_vsid_o = '0;
    assign trap_v_o    = 1'b0;
`endif

    // Eligibility is re-evaluated every cycle against live core state.
    always_comb begin
        cur_ie = 1'b0;
        cur_il = '0;
        cur_th = '0;
        case (mode_q)
            MODE_M: begin
                cur_ie = mie_i;
                cur_il = mil_i;
                cur_th = mthresh_i;
            end
            MODE_S: begin
                cur_ie = sie_i;
                cur_il = sil_i;
                cur_th = sthresh_i;
            end
            default: begin
                cur_ie = 1'b0;
                cur_il = '0;
                cur_th = '0;
            end
        endcase
        cur_floor = (cur_il > cur_th) ? cur_il : cur_th;
        if (mode_q > priv_i) begin
            elig = 1'b1;
        end else if (mode_q == priv_i) begin
            elig = cur_ie && (level_q > cur_floor);
        end else begin
            elig = 1'b0;
        end
        elig = elig && virt_match;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (irq_valid_i) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (irq_kill_req_i) begin
                    state_d = ST_KILL;
                end else if (!irq_valid_i) begin
                    state_d = ST_IDLE;
                end else if (elig && take_ok_i) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A commit from the core wins over a simultaneous abort.
                if (trap_ack_i) begin
                    state_d = ST_HSK;
                end else if (irq_kill_req_i) begin
                    state_d = ST_KILL;
                end else if (!irq_valid_i) begin
                    state_d = ST_IDLE;
                end else if (!elig || !take_ok_i) begin
                    state_d = ST_PEND;
                end
            end
            ST_HSK:  state_d = ST_IDLE;
            ST_KILL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            level_q <= '0;
            mode_q  <= '0;
            shv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            level_q <= level_d;
            mode_q  <= mode_d;
            shv_q   <= shv_d;
        end
    end

    assign trap_req_o     = (state_q == ST_REQ);
    assign irq_ready_o    = (state_q == ST_HSK);
    assign irq_kill_ack_o = (state_q == ST_KILL);
    assign trap_id_o      = id_q;
    assign trap_level_o   = level_q;
    assign trap_mode_o    = mode_q;
    assign trap_shv_o     = shv_q;

endmodule

// File: tb/tb_clic_core_rx.sv
// Self-checking bench for clic_core_rx: directed scenarios then randomized traffic against a behavioural handshake model.
module tb_clic_core_rx;
    localparam int SW = 8;
    localparam int PW = 8;
    localparam int MW = 2;
    localparam int VW = 6;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          irq_valid_i = 0, irq_v_i = 0, irq_shv_i = 0, irq_kill_req_i = 0;
    logic [SW-1:0] irq_id_i = '0;
    logic [PW-1:0] irq_max_i = '0;
    logic [MW-1:0] irq_mode_i = '0;
    logic [VW-1:0] irq_vsid_i = '0;
    logic [MW-1:0] priv_i = '0;
    logic          mie_i = 0, sie_i = 0, virt_i = 0, take_ok_i = 0, trap_ack_i = 0;
    logic [PW-1:0] mil_i = '0, sil_i = '0, mthresh_i = '0, sthresh_i = '0;
    logic [VW-1:0] cur_vsid_i = '0;
    logic          irq_ready_o, irq_kill_ack_o, trap_req_o, trap_v_o, trap_shv_o;
    logic [SW-1:0] trap_id_o;
    logic [PW-1:0] trap_level_o;
    logic [MW-1:0] trap_mode_o;
    logic [VW-1:0] trap_vsid_o;

    clic_core_rx dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .irq_valid_i(irq_valid_i), .irq_ready_o(irq_ready_o),
        .irq_id_i(irq_id_i), .irq_max_i(irq_max_i), .irq_mode_i(irq_mode_i),
        .irq_vsid_i(irq_vsid_i), .irq_v_i(irq_v_i), .irq_shv_i(irq_shv_i),
        .irq_kill_req_i(irq_kill_req_i), .irq_kill_ack_o(irq_kill_ack_o),
        .priv_i(priv_i), .mie_i(mie_i), .sie_i(sie_i), .mil_i(mil_i), .sil_i(sil_i),
        .mthresh_i(mthresh_i), .sthresh_i(sthresh_i), .virt_i(virt_i),
        .cur_vsid_i(cur_vsid_i), .take_ok_i(take_ok_i),
        .trap_req_o(trap_req_o), .trap_ack_i(trap_ack_i),
        .trap_id_o(trap_id_o), .trap_level_o(trap_level_o), .trap_mode_o(trap_mode_o),
        .trap_vsid_o(trap_vsid_o), .trap_v_o(trap_v_o), .trap_shv_o(trap_shv_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: whether an irq is held, and which handshake output is expected now.
    bit            m_held, m_req, m_ready, m_kill;
    logic [SW-1:0] m_id;
    logic [PW-1:0] m_lvl;
    logic [MW-1:0] m_mode;
    logic [VW-1:0] m_vsid;
    logic          m_v, m_shv;

    task automatic model_reset();
        m_held = 0; m_req = 0; m_ready = 0; m_kill = 0;
        m_id = '0; m_lvl = '0; m_mode = '0; m_vsid = '0; m_v = 0; m_shv = 0;
    endtask

    function automatic bit ref_elig();
        int mode = int'(m_mode);
        int priv = int'(priv_i);
        int ie = 0;
        int il = 0;
        int th = 0;
        int floor_lvl;
        bit ok;
        if (mode == 3) begin ie = int'(mie_i); il = int'(mil_i); th = int'(mthresh_i); end
        if (mode == 1) begin ie = int'(sie_i); il = int'(sil_i); th = int'(sthresh_i); end
        floor_lvl = (il > th) ? il : th;
        if (mode > priv)       ok = 1;
        else if (mode < priv)  ok = 0;
        else                   ok = (ie != 0) && (int'(m_lvl) > floor_lvl);
`ifdef CLIC_RX_VIRT_EN
        if (m_v && !(virt_i && m_vsid == cur_vsid_i)) ok = 0;
`endif
        return ok;
    endfunction

    task automatic model_edge();
        if (m_ready || m_kill) begin
            m_ready = 0; m_kill = 0; m_held = 0; m_req = 0;
        end else if (!m_held) begin
            if (irq_valid_i) begin
                m_held = 1;
                m_id = irq_id_i; m_lvl = irq_max_i; m_mode = irq_mode_i;
                m_vsid = irq_vsid_i; m_v = irq_v_i; m_shv = irq_shv_i;
            end
        end else if (m_req && trap_ack_i) begin
            m_ready = 1; m_req = 0;
        end else if (irq_kill_req_i) begin
            m_kill = 1; m_req = 0;
        end else if (!irq_valid_i) begin
            m_held = 0; m_req = 0;
        end else begin
            m_req = ref_elig() && take_ok_i;
        end
    endtask

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("trap_req", trap_req_o, m_req);
        check("irq_ready", irq_ready_o, m_ready);
        check("kill_ack", irq_kill_ack_o, m_kill);
        check("ready_kill_excl", irq_ready_o & irq_kill_ack_o, 0);
        check("trap_id", trap_id_o, m_id);
        check("trap_level", trap_level_o, m_lvl);
        check("trap_mode", trap_mode_o, m_mode);
        check("trap_shv", trap_shv_o, m_shv);
`ifdef CLIC_RX_VIRT_EN
        check("trap_v", trap_v_o, m_v);
        check("trap_vsid", trap_vsid_o, m_vsid);
`else
        check("trap_v", trap_v_o, 0);
        check("trap_vsid", trap_vsid_o, 0);
`endif
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        check_all();
    endtask

    task automatic offer(input int id, input int lvl, input int mode, input bit v, input int vsid, input bit shv);
        irq_valid_i = 1;
        irq_id_i = SW'(id); irq_max_i = PW'(lvl); irq_mode_i = MW'(mode);
        irq_v_i = v; irq_vsid_i = VW'(vsid); irq_shv_i = shv;
    endtask

    task automatic quiet();
        irq_valid_i = 0; irq_kill_req_i = 0; trap_ack_i = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk_i);
        check_all();
        rst_ni = 1;
        take_ok_i = 1;

        // 1: basic take and commit
        priv_i = 2'b11; mie_i = 1; mil_i = 0; mthresh_i = 0;
        offer(5, 8'h80, 3, 0, 0, 1);
        step(); step();
        check("t1_req_at_2", trap_req_o, 1);
        check("t1_id", trap_id_o, 5);
        trap_ack_i = 1; step();
        quiet(); step(); step();

        // 2: level below mil, held then killed
        mil_i = 8'h80;
        offer(9, 8'h40, 3, 0, 0, 0);
        repeat (20) step();
        irq_kill_req_i = 1; step();
        check("t2_kill_ack", irq_kill_ack_o, 1);
        quiet(); step(); step();

        // 3+4: higher target privilege ignores xIE/level; ack beats kill
        priv_i = 2'b00; mie_i = 0; mil_i = 0;
        offer(17, 1, 3, 0, 0, 0);
        step(); step();
        check("t3_req", trap_req_o, 1);
        trap_ack_i = 1; irq_kill_req_i = 1; step();
        check("t4_ready", irq_ready_o, 1);
        quiet(); step(); step();

        // 5: withdraw in REQ, then mil raised in REQ
        priv_i = 2'b11; mie_i = 1; mil_i = 0;
        offer(33, 8'h90, 3, 0, 0, 0);
        step(); step();
        irq_valid_i = 0; step();
        check("t5_withdraw", trap_req_o, 0);
        offer(34, 8'h90, 3, 0, 0, 0);
        step(); step(); step();
        mil_i = 8'hFF; step();
        check("t5_back_pend", trap_req_o, 0);
        quiet(); mil_i = 0; step(); step();

        // 6: virtual irq with guest id mismatch, then match; then async reset in REQ
        virt_i = 1; cur_vsid_i = 2;
        offer(40, 8'h80, 3, 1, 3, 0);
        repeat (5) step();
        cur_vsid_i = 3; step(); step();
        check("t6_req", trap_req_o, 1);
        #2 rst_ni = 0;
        #1 model_reset();
        check_all();
        quiet(); virt_i = 0;
        @(negedge clk_i);
        rst_ni = 1;
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int pv;
            irq_valid_i    = ($urandom_range(0, 7) != 0);
            irq_id_i       = SW'($urandom);
            irq_max_i      = PW'($urandom_range(0, 15) * 16);
            pv             = $urandom_range(0, 2);
            irq_mode_i     = (pv == 2) ? 2'b11 : MW'(pv);
            irq_v_i        = $urandom_range(0, 1);
            irq_vsid_i     = VW'($urandom_range(0, 3));
            irq_shv_i      = $urandom_range(0, 1);
            irq_kill_req_i = ($urandom_range(0, 15) == 0);
            trap_ack_i     = ($urandom_range(0, 3) == 0);
            take_ok_i      = ($urandom_range(0, 5) != 0);
            pv             = $urandom_range(0, 2);
            priv_i         = (pv == 2) ? 2'b11 : MW'(pv);
            mie_i          = ($urandom_range(0, 3) != 0);
            sie_i          = ($urandom_range(0, 3) != 0);
            mil_i          = PW'($urandom_range(0, 15) * 16);
            sil_i          = PW'($urandom_range(0, 15) * 16);
            mthresh_i      = PW'($urandom_range(0, 15) * 16);
            sthresh_i      = PW'($urandom_range(0, 15) * 16);
            virt_i         = $urandom_range(0, 1);
            cur_vsid_i     = VW'($urandom_range(0, 3));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
